fp_acc_sched: RTL and testbench



---
 rtl/fp_acc_sched.sv | 145 ++++++++++++++
 tb/tb_fp_acc_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_acc_sched.sv
// Purpose  : streams IEEE-754 singles through an external LAT-stage adder as LAT interleaved partial sums, then reduces them to one sum.
// Latency  : done/result appear LAT*LAT+1 cycles after the cycle following the sampled finished pulse, whatever the sample count.
// Backpress: none; a sample is taken on every valid cycle in ACCUM and the stream cannot be stalled.
//
// Ports: clk/reset_n (async active-low); start, valid, data[31:0], finished from the producer;
//        add_a/add_b (registered operands) and add_res to the external adder; busy, done, result[31:0] to the consumer.
// Option: define FP_ACC_SCHED_COUNT_EN to add sample_count[15:0] (accepted samples, saturating).
module fp_acc_sched #(
    parameter int LAT = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        valid,
    input  logic [31:0] data,
    input  logic        finished,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_res,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
`ifdef FP_ACC_SCHED_COUNT_EN
    ,
    output logic [15:0] sample_count
`endif
);

    localparam logic [3:0] LATC = 4'(LAT);

    typedef enum logic [2:0] {IDLE, ACCUM, COLLECT, REDUCE, DONE} state_t;

    state_t      state;
    logic [3:0]  prime_cnt;   // ACCUM cycles left before add_res carries a real partial sum
    logic [3:0]  acc_cnt;     // ACCUM cycles elapsed, saturating at LAT
    logic [3:0]  slot;        // COLLECT cycle index
    logic [3:0]  iter;        // REDUCE iteration
    logic [3:0]  phase;       // position within one LAT-cycle REDUCE iteration
    logic [31:0] slot_buf [16];
    logic [3:0]  nxt_idx;

    assign nxt_idx = iter + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            add_a     <= '0;
            add_b     <= '0;
            result    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            prime_cnt <= '0;
            acc_cnt   <= '0;
            slot      <= '0;
            iter      <= '0;
            phase     <= '0;
            for (int i = 0; i < 16; i++) slot_buf[i] <= '0;
`ifdef FP_ACC_SCHED_COUNT_EN
            sample_count <= '0;
`endif
        end else if (start) begin
            // start aborts whatever is in flight; stale adder contents are masked by prime_cnt
            state     <= ACCUM;
            add_a     <= '0;
            add_b     <= '0;
            result    <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            prime_cnt <= LATC;
            acc_cnt   <= '0;
            slot      <= '0;
            iter      <= '0;
            phase     <= '0;
            for (int i = 0; i < 16; i++) slot_buf[i] <= '0;
`ifdef FP_ACC_SCHED_COUNT_EN
            sample_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    add_a <= '0;
                    add_b <= '0;
                end
                ACCUM: begin
                    add_a <= valid ? data : '0;
                    // add_res now holds the partial sum issued LAT cycles ago in this slot
                    add_b <= (prime_cnt != 4'd0) ? '0 : add_res;
                    if (prime_cnt != 4'd0) prime_cnt <= prime_cnt - 4'd1;
                    if (acc_cnt != LATC) acc_cnt <= acc_cnt + 4'd1;
`ifdef FP_ACC_SCHED_COUNT_EN
                    if (valid && sample_count != 16'hFFFF) sample_count <= sample_count + 16'd1;
`endif
                    if (finished) begin
                        state <= COLLECT;
                        slot  <= '0;
                    end
                end
                COLLECT: begin
                    add_a <= '0;
                    add_b <= '0;
                    // slot k was issued LAT-1-k cycles before finished; zero it if ACCUM was shorter
                    slot_buf[slot] <= (acc_cnt < (LATC - slot)) ? '0 : add_res;
                    if (slot == LATC - 4'd1) begin
                        state <= REDUCE;
                        iter  <= '0;
                        phase <= '0;
                    end else begin
                        slot <= slot + 4'd1;
                    end
                end
                REDUCE: begin
                    add_a <= '0;
                    add_b <= '0;
                    if (phase == 4'd0) begin
                        if (iter == LATC - 4'd1) begin
                            result <= add_res;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end else if (iter == 4'd0) begin
                            add_a <= slot_buf[0];
                            add_b <= slot_buf[1];
                        end else begin
                            // previous iteration's sum arrives exactly on this cycle
                            add_a <= add_res;
                            add_b <= slot_buf[nxt_idx];
                        end
                    end
                    if (phase == LATC - 4'd1) begin
                        phase <= '0;
                        iter  <= iter + 4'd1;
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_acc_sched.sv
// Purpose  : self-checking bench for fp_acc_sched with an integer-exact adder model attached.
// Latency  : expects done exactly LAT*LAT+1 cycles after the first cycle following finished.
// Backpress: none; inputs are driven freely, including junk outside ACCUM.
module tb_fp_acc_sched;

    localparam int LAT = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic        finished = 1'b0;
    logic [31:0] data = '0;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_res;
    logic        busy;
    logic        done;
    logic [31:0] result;
`ifdef FP_ACC_SCHED_COUNT_EN
    logic [15:0] sample_count;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fp_acc_sched #(.LAT(LAT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .valid    (valid),
        .data     (data),
        .finished (finished),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_res  (add_res),
        .busy     (busy),
        .done     (done),
        .result   (result)
`ifdef FP_ACC_SCHED_COUNT_EN
        ,
        .sample_count (sample_count)
`endif
    );

    // Conversions valid for non-negative integers below 2^24 (all values used here).
    function automatic int fp2int(input logic [31:0] f);
        int e;
        int m;
        e = int'(f[30:23]);
        if (e == 0) return 0;
        m = int'({1'b1, f[22:0]});
        if (e >= 150) return m <<< (e - 150);
        return m >>> (150 - e);
    endfunction

    function automatic logic [31:0] int2fp(input int v);
        int p;
        logic [31:0] mv;
        if (v <= 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if (v[i]) p = i;
        if (p >= 23) mv = v >> (p - 23);
        else         mv = v << (23 - p);
        return {1'b0, 8'(p + 127), mv[22:0]};
    endfunction

    // Adder model: operands the controller registers in cycle c come back on add_res in cycle c+LAT,
    // i.e. LAT-1 pipeline stages behind the registered operand ports.
    logic [31:0] pipe [LAT-1];
    always @(posedge clk) begin
        pipe[0] <= int2fp(fp2int(add_a) + fp2int(add_b));
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign add_res = pipe[LAT-2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done (bounded); we are in cycle F+1 on entry.
    task automatic wait_done(input int sum, input int nacc, input bit junk, input string tag);
        int i;
        i = 1;
        while (done !== 1'b1 && i < LAT * LAT + 20) begin
            if (i == LAT) chk({tag, ".busy_mid"}, 32'(busy), 32'd1);
            if (junk) begin
                valid    = 1'($urandom_range(0, 1));
                data     = int2fp(int'($urandom_range(1, 50)));
                finished = ($urandom_range(0, 5) == 0);
            end
            tick();
            i++;
        end
        valid    = 1'b0;
        finished = 1'b0;
        chk({tag, ".latency"}, 32'(i), 32'(LAT * LAT + 2));
        chk({tag, ".result"}, result, int2fp(sum));
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
`ifdef FP_ACC_SCHED_COUNT_EN
        chk({tag, ".sample_count"}, 32'(sample_count), 32'(nacc));
`else
        if (nacc < 0) chk({tag, ".nacc"}, 32'(nacc), 32'd0);
`endif
        tick();
        chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, ".result_held"}, result, int2fp(sum));
    endtask

    // val_mode: >=0 constant sample value, -1 random 0..15, -2 ramp 1,2,3...
    task automatic run(input int n, input int val_mode, input bit gaps, input bit fin_on_last,
                       input bit junk, input bit fin_with_start, input string tag);
        int sum;
        int cnt;
        int v;
        sum = 0;
        cnt = 0;
        start    = 1'b1;
        finished = fin_with_start;
        valid    = 1'b0;
        tick();
        start    = 1'b0;
        finished = 1'b0;
        chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
        while (cnt < n) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                valid    = 1'b0;
                data     = int2fp(77);
                finished = 1'b0;
            end else begin
                if (val_mode == -1)      v = int'($urandom_range(0, 15));
                else if (val_mode == -2) v = cnt + 1;
                else                     v = val_mode;
                data     = int2fp(v);
                valid    = 1'b1;
                sum     += v;
                cnt++;
                finished = fin_on_last && (cnt == n);
            end
            tick();
        end
        if (!(fin_on_last && n > 0)) begin
            valid    = 1'b0;
            finished = 1'b1;
            tick();
        end
        valid    = 1'b0;
        finished = 1'b0;
        wait_done(sum, n, junk, tag);
    endtask

    initial begin
        int dc;

        // reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst.add_a", add_a, 32'h0);
        chk("rst.add_b", add_b, 32'h0);
        chk("rst.result", result, 32'h0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        run(10, 1, 1'b0, 1'b0, 1'b0, 1'b0, "ten_ones");
        chk("ten_ones.value", result, 32'h41200000);

        run(3, -2, 1'b0, 1'b1, 1'b0, 1'b0, "one_two_three");
        chk("one_two_three.value", result, 32'h40C00000);

        run(0, 1, 1'b0, 1'b0, 1'b0, 1'b0, "empty");
        chk("empty.value", result, 32'h00000000);

        run(20, 2, 1'b1, 1'b0, 1'b1, 1'b0, "twenty_twos");
        chk("twenty_twos.value", result, 32'h42200000);

        for (int r = 0; r < 3; r++)
            run(int'($urandom_range(0, 25)), -1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, "random");

        // abort mid-REDUCE; restart shares its cycle with a finished pulse
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            valid = 1'b1;
            data  = int2fp(3);
            tick();
        end
        valid    = 1'b0;
        finished = 1'b1;
        tick();
        finished = 1'b0;
        dc = 0;
        for (int k = 0; k < 20; k++) begin
            dc += int'(done);
            tick();
        end
        chk("abort.no_early_done", 32'(dc), 32'd0);
        run(4, 1, 1'b0, 1'b1, 1'b0, 1'b1, "abort");
        chk("abort.value", result, 32'h40800000);
        dc = 0;
        for (int k = 0; k < 60; k++) begin
            dc += int'(done);
            tick();
        end
        chk("abort.no_late_done", 32'(dc), 32'd0);

        // asynchronous reset during COLLECT
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1;
            data  = int2fp(5);
            tick();
        end
        valid    = 1'b0;
        finished = 1'b1;
        tick();
        finished = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_collect.busy", 32'(busy), 32'd0);
        chk("rst_collect.done", 32'(done), 32'd0);
        chk("rst_collect.add_a", add_a, 32'h0);
        chk("rst_collect.add_b", add_b, 32'h0);
        chk("rst_collect.result", result, 32'h0);
        tick();
        reset_n = 1'b1;
        dc = 0;
        for (int k = 0; k < 80; k++) begin
            dc += int'(done);
            tick();
        end
        chk("rst_collect.no_done", 32'(dc), 32'd0);
        chk("rst_collect.busy_idle", 32'(busy), 32'd0);

        run(12, -1, 1'b1, 1'b0, 1'b1, 1'b0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
